// File: rtl/mid_buffer_pkg.sv
// Shared types and default geometry for the sliding-window buffer.
package mid_buffer_pkg;

  typedef enum logic {
    MODE_POOL = 1'b0,
    MODE_CONV = 1'b1
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FILL = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  localparam int unsigned DEF_CH    = 32;
  localparam int unsigned DEF_DW    = 32;
  localparam int unsigned DEF_IMG_H = 34;
  localparam int unsigned DEF_IMG_W = 26;
  localparam int unsigned DEF_WIN   = 2;

endpackage

// File: rtl/line_buffer.sv
// One image row of pixels; the read port prefetches the column needed by the next pixel.
module line_buffer #(
  parameter int unsigned DEPTH = 26,
  parameter int unsigned WIDTH = 1024
) (
  input  logic                     clk,
  input  logic                     i_en,
  input  logic [$clog2(DEPTH)-1:0] i_waddr,
  input  logic [$clog2(DEPTH)-1:0] i_raddr,
  input  logic [WIDTH-1:0]         i_wdata,
  output logic [WIDTH-1:0]         o_rdata
);

  logic [WIDTH-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_en) begin
      r_mem[i_waddr] <= i_wdata;
      o_rdata        <= r_mem[i_raddr];
    end
  end

endmodule

// File: rtl/mid_window_buffer.sv
// Raster-scan WIN x WIN window generator with pool (stride WIN) and conv (stride 1) modes.
// Note: rst_n is an active-high synchronous reset despite its name.
module mid_window_buffer
  import mid_buffer_pkg::*;
#(
  parameter int unsigned CH    = DEF_CH,
  parameter int unsigned DW    = DEF_DW,
  parameter int unsigned IMG_H = DEF_IMG_H,
  parameter int unsigned IMG_W = DEF_IMG_W,
  parameter int unsigned WIN   = DEF_WIN
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         valid_in,
  output logic                         in_ready,
  input  logic [CH*DW-1:0]             data_in,
  input  logic                         mode,
  output logic                         valid_out,
  input  logic                         out_ready,
  output logic [CH*WIN*WIN*DW-1:0]     win_out,
  output logic [$clog2(IMG_H)-1:0]     win_row,
  output logic [$clog2(IMG_W)-1:0]     win_col,
  output logic                         frame_done
);

  localparam int unsigned PXW = CH * DW;
  localparam int unsigned RW  = $clog2(IMG_H);
  localparam int unsigned CW  = $clog2(IMG_W);
  localparam int unsigned PW  = $clog2(WIN);

  state_e                  r_state, w_state_nxt;
  mode_e                   r_mode, w_mode;
  logic [RW-1:0]           r_row;
  logic [CW-1:0]           r_col;
  logic [PW-1:0]           r_rph, r_cph;
  logic                    r_valid, r_done;
  logic [RW-1:0]           r_win_row;
  logic [CW-1:0]           r_win_col;
  logic [CH*WIN*WIN*DW-1:0] r_win;

  logic                    w_acc, w_first, w_col_end, w_last, w_fill_end, w_emit;
  logic [CW-1:0]           w_col_nxt;
  logic [PXW-1:0]          w_lb_wd [WIN-1];
  logic [PXW-1:0]          w_lb_rd [WIN-1];
  logic [PXW-1:0]          w_col [WIN];

  assign in_ready   = !(r_valid && !out_ready);
  assign w_acc      = valid_in && in_ready;
  assign w_first    = (r_state == ST_IDLE) || (r_state == ST_DONE);
  assign w_mode     = w_first ? mode_e'(mode) : r_mode;
  assign w_col_end  = (r_col == CW'(IMG_W - 1));
  assign w_last     = w_col_end && (r_row == RW'(IMG_H - 1));
  assign w_fill_end = (r_row == RW'(WIN - 1)) && (r_col == CW'(WIN - 1));
  assign w_col_nxt  = w_col_end ? '0 : r_col + CW'(1);
  // Phase counters hold row/col mod WIN; pool windows complete when both phases hit WIN-1.
  assign w_emit     = (r_row >= RW'(WIN - 1)) && (r_col >= CW'(WIN - 1)) &&
                      ((w_mode == MODE_CONV) ||
                       ((r_rph == PW'(WIN - 1)) && (r_cph == PW'(WIN - 1))));

  // Chain of row buffers: buffer j holds row r-1-j; the read port is aimed at the next column.
  for (genvar j = 0; j < WIN - 1; j++) begin : g_lb
    if (j == 0) begin : g_head
      assign w_lb_wd[j] = data_in;
    end else begin : g_tail
      assign w_lb_wd[j] = w_lb_rd[j-1];
    end
    line_buffer #(
      .DEPTH (IMG_W),
      .WIDTH (PXW)
    ) u_lb (
      .clk     (clk),
      .i_en    (w_acc),
      .i_waddr (r_col),
      .i_raddr (w_col_nxt),
      .i_wdata (w_lb_wd[j]),
      .o_rdata (w_lb_rd[j])
    );
  end

  for (genvar r = 0; r < WIN; r++) begin : g_col
    if (r == WIN - 1) begin : g_new
      assign w_col[r] = data_in;
    end else begin : g_old
      assign w_col[r] = w_lb_rd[WIN-2-r];
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (w_acc) w_state_nxt = ST_FILL;
      ST_FILL: begin
        if (w_acc && w_last)          w_state_nxt = ST_DONE;
        else if (w_acc && w_fill_end) w_state_nxt = ST_RUN;
      end
      ST_RUN:  if (w_acc && w_last) w_state_nxt = ST_DONE;
      ST_DONE: w_state_nxt = w_acc ? ST_FILL : ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Raster position and stride phases.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      r_row  <= '0;
      r_col  <= '0;
      r_rph  <= '0;
      r_cph  <= '0;
      r_mode <= MODE_POOL;
    end else if (w_acc) begin
      if (w_first) r_mode <= mode_e'(mode);
      r_col <= w_col_nxt;
      if (w_col_end) begin
        r_cph <= '0;
        if (w_last) begin
          r_row <= '0;
          r_rph <= '0;
        end else begin
          r_row <= r_row + RW'(1);
          r_rph <= (r_rph == PW'(WIN - 1)) ? '0 : r_rph + PW'(1);
        end
      end else begin
        r_cph <= (r_cph == PW'(WIN - 1)) ? '0 : r_cph + PW'(1);
      end
    end
  end

  // Window presentation handshake; a held window blocks input so its fields cannot move.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      r_valid   <= 1'b0;
      r_done    <= 1'b0;
      r_win_row <= '0;
      r_win_col <= '0;
    end else begin
      r_done <= w_acc && w_last;
      if (w_acc) begin
        r_valid <= w_emit;
        if (w_emit) begin
          r_win_row <= r_row - RW'(WIN - 1);
          r_win_col <= r_col - CW'(WIN - 1);
        end
      end else if (out_ready) begin
        r_valid <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      r_win <= '0;
    end else if (w_acc) begin
      for (int c = 0; c < int'(CH); c++) begin
        for (int r = 0; r < int'(WIN); r++) begin
          for (int k = 0; k < int'(WIN); k++) begin
            if (k == int'(WIN) - 1)
              r_win[((c*WIN+r)*WIN+k)*DW +: DW] <= w_col[r][c*DW +: DW];
            else
              r_win[((c*WIN+r)*WIN+k)*DW +: DW] <= r_win[((c*WIN+r)*WIN+k+1)*DW +: DW];
          end
        end
      end
    end
  end

  assign valid_out  = r_valid;
  assign frame_done = r_done;
  assign win_row    = r_win_row;
  assign win_col    = r_win_col;
  assign win_out    = r_win;

endmodule

// File: tb/tb_mid_window_buffer.sv
// Bench for mid_window_buffer: default and small generic instances against a frame-level model.
module tb_mid_window_buffer;

  logic clk = 1'b0;
  logic rst;
  logic vin [2];
  logic md [2];
  logic ordy [2];
  logic [1023:0] d_in [2];

  logic in_ready0, valid_out0, frame_done0;
  logic [4095:0] w_out0;
  logic [5:0] win_row0;
  logic [4:0] win_col0;
  logic in_ready1, valid_out1, frame_done1;
  logic [1151:0] w_out1;
  logic [2:0] win_row1;
  logic [2:0] win_col1;

  always #5 clk = ~clk;

  mid_window_buffer u0 (
    .clk(clk), .rst_n(rst), .valid_in(vin[0]), .in_ready(in_ready0),
    .data_in(d_in[0]), .mode(md[0]), .valid_out(valid_out0), .out_ready(ordy[0]),
    .win_out(w_out0), .win_row(win_row0), .win_col(win_col0), .frame_done(frame_done0)
  );

  mid_window_buffer #(.CH(4), .DW(32), .IMG_H(6), .IMG_W(6), .WIN(3)) u1 (
    .clk(clk), .rst_n(rst), .valid_in(vin[1]), .in_ready(in_ready1),
    .data_in(d_in[1][127:0]), .mode(md[1]), .valid_out(valid_out1), .out_ready(ordy[1]),
    .win_out(w_out1), .win_row(win_row1), .win_col(win_col1), .frame_done(frame_done1)
  );

  function automatic int g_w(input int i);   return (i == 0) ? 26 : 6; endfunction
  function automatic int g_h(input int i);   return (i == 0) ? 34 : 6; endfunction
  function automatic int g_n(input int i);   return (i == 0) ? 2 : 3;  endfunction
  function automatic int g_ch(input int i);  return (i == 0) ? 32 : 4; endfunction

  int checks = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", nm, act, exp);
    end
  endtask

  task automatic chk_win(input string nm, input logic [4095:0] act, input logic [4095:0] exp);
    int bad;
    checks++;
    if (act !== exp) begin
      failures++;
      bad = 0;
      for (int j = 127; j >= 0; j--)
        if (act[j*32 +: 32] !== exp[j*32 +: 32]) bad = j;
      $display("FAIL %s word %0d actual=0x%0h required=0x%0h", nm, bad,
               act[bad*32 +: 32], exp[bad*32 +: 32]);
    end
  endtask

  // Frame-level model: accepted pixel store plus the expected presented window.
  int unsigned pix [2][34][26][32];
  int  m_r [2];
  int  m_c [2];
  bit  m_mode [2];
  bit  e_valid [2];
  bit  e_done [2];
  int  e_row [2];
  int  e_col [2];

  function automatic logic [4095:0] exp_win(input int i, input int row, input int col);
    logic [4095:0] v;
    int n;
    v = '0;
    n = g_n(i);
    for (int ch = 0; ch < g_ch(i); ch++)
      for (int rr = 0; rr < n; rr++)
        for (int k = 0; k < n; k++)
          v[((ch*n+rr)*n+k)*32 +: 32] = pix[i][row+rr][col+k][ch];
    return v;
  endfunction

  int win_cnt [2];
  int held [2];
  int irlow [2];
  int cyc = 0;
  int t00, t01;
  logic [4095:0] cap00;
  bit done_seen, done_v;
  int done_r, done_c;
  int q1 [$];

  bit a_v, a_d, a_ir, e_ir, acc_m, emit;
  int a_r, a_c, n_m;
  logic [4095:0] a_w;

  always @(negedge clk) begin
    cyc++;
    for (int i = 0; i < 2; i++) begin
      a_v  = (i == 0) ? valid_out0  : valid_out1;
      a_d  = (i == 0) ? frame_done0 : frame_done1;
      a_ir = (i == 0) ? in_ready0   : in_ready1;
      a_r  = (i == 0) ? int'(win_row0) : int'(win_row1);
      a_c  = (i == 0) ? int'(win_col0) : int'(win_col1);
      a_w  = (i == 0) ? w_out0 : 4096'(w_out1);
      e_ir = !(e_valid[i] && !ordy[i]);
      chk($sformatf("u%0d.valid_out", i), 64'(a_v), 64'(e_valid[i]));
      chk($sformatf("u%0d.frame_done", i), 64'(a_d), 64'(e_done[i]));
      chk($sformatf("u%0d.in_ready", i), 64'(a_ir), 64'(e_ir));
      if (e_valid[i]) begin
        chk($sformatf("u%0d.win_row", i), 64'(a_r), 64'(e_row[i]));
        chk($sformatf("u%0d.win_col", i), 64'(a_c), 64'(e_col[i]));
        chk_win($sformatf("u%0d.win_out(%0d,%0d)", i, e_row[i], e_col[i]), a_w,
                exp_win(i, e_row[i], e_col[i]));
      end
      if (a_v && ordy[i]) begin
        win_cnt[i]++;
        if (i == 0 && a_r == 0 && a_c == 0) begin cap00 = a_w; t00 = cyc; end
        if (i == 0 && a_r == 0 && a_c == 1) t01 = cyc;
        if (i == 1) q1.push_back(a_r * 8 + a_c);
      end
      if (a_v && !ordy[i]) held[i]++;
      if (!a_ir) irlow[i]++;
      if (i == 0 && a_d) begin
        done_seen = 1'b1; done_v = a_v; done_r = a_r; done_c = a_c;
      end
      if (rst) begin
        m_r[i] = 0; m_c[i] = 0; e_valid[i] = 0; e_done[i] = 0; e_row[i] = 0; e_col[i] = 0;
      end else begin
        acc_m = vin[i] && e_ir;
        e_done[i] = 1'b0;
        if (acc_m) begin
          n_m = g_n(i);
          if (m_r[i] == 0 && m_c[i] == 0) m_mode[i] = md[i];
          for (int ch = 0; ch < g_ch(i); ch++)
            pix[i][m_r[i]][m_c[i]][ch] = d_in[i][ch*32 +: 32];
          emit = (m_r[i] >= n_m - 1) && (m_c[i] >= n_m - 1) &&
                 (m_mode[i] || (((m_r[i] - n_m + 1) % n_m == 0) && ((m_c[i] - n_m + 1) % n_m == 0)));
          e_valid[i] = emit;
          if (emit) begin e_row[i] = m_r[i] - n_m + 1; e_col[i] = m_c[i] - n_m + 1; end
          e_done[i] = (m_r[i] == g_h(i) - 1) && (m_c[i] == g_w(i) - 1);
          if (m_c[i] == g_w(i) - 1) begin
            m_c[i] = 0;
            m_r[i] = (m_r[i] == g_h(i) - 1) ? 0 : m_r[i] + 1;
          end else begin
            m_c[i]++;
          end
        end else if (ordy[i]) begin
          e_valid[i] = 1'b0;
        end
      end
    end
  end

  // out_ready shaping: random per-cycle, or a single 5-cycle hold on window (2,4).
  bit rnd_or [2];
  bit bp_en, bp_fired;
  int bp_left;

  always @(posedge clk) begin
    #1;
    for (int i = 0; i < 2; i++)
      if (rnd_or[i]) ordy[i] = ($urandom_range(3) != 0);
    if (bp_en) begin
      if (bp_left > 0) begin
        bp_left--;
        if (bp_left == 0) ordy[0] = 1'b1;
      end else if (!bp_fired && valid_out0 && win_row0 == 6'd2 && win_col0 == 5'd4) begin
        ordy[0] = 1'b0; bp_left = 5; bp_fired = 1'b1;
      end
    end
  end

  function automatic logic [1023:0] rnd_px();
    logic [1023:0] v;
    for (int j = 0; j < 32; j++) v[j*32 +: 32] = $urandom;
    return v;
  endfunction

  task automatic drive_frame(input int i, input int npix, input bit mode_v, input int flip_at,
                             input bit rnd, input int gap_pct);
    bit m, acc;
    int tries, r, c, gaps;
    logic [1023:0] d;
    m = mode_v;
    for (int p = 0; p < npix; p++) begin
      r = p / g_w(i);
      c = p % g_w(i);
      if (p == flip_at) m = !m;
      gaps = 0;
      while (gap_pct > 0 && gaps < 20 && int'($urandom_range(99)) < gap_pct) begin
        vin[i] = 1'b0; d_in[i] = rnd_px(); md[i] = m;
        @(posedge clk); #1;
        gaps++;
      end
      d = rnd ? rnd_px() : '0;
      if (!rnd)
        for (int ch = 0; ch < g_ch(i); ch++) d[ch*32 +: 32] = 32'((ch << 16) | (r << 8) | c);
      vin[i] = 1'b1; d_in[i] = d; md[i] = m;
      tries = 0; acc = 1'b0;
      while (!acc && tries < 200) begin
        @(negedge clk);
        acc = vin[i] && ((i == 0) ? in_ready0 : in_ready1);
        @(posedge clk); #1;
        tries++;
      end
      chk($sformatf("u%0d.accept_px%0d", i, p), 64'(acc), 64'd1);
    end
    vin[i] = 1'b0;
  endtask

  task automatic settle();
    repeat (8) @(posedge clk);
    #1;
  endtask

  task automatic clear_stats();
    win_cnt[0] = 0; win_cnt[1] = 0; held[0] = 0; held[1] = 0; irlow[0] = 0; irlow[1] = 0;
    cap00 = '0; done_seen = 0; done_v = 0; done_r = -1; done_c = -1; t00 = -100; t01 = -200;
    bp_fired = 0; bp_left = 0;
    q1.delete();
  endtask

  task automatic chk_first_pool(input string tag);
    chk({tag, ".ch5(0,0)"}, 64'(cap00[20*32 +: 32]), 64'h50000);
    chk({tag, ".ch5(0,1)"}, 64'(cap00[21*32 +: 32]), 64'h50001);
    chk({tag, ".ch5(1,0)"}, 64'(cap00[22*32 +: 32]), 64'h50100);
    chk({tag, ".ch5(1,1)"}, 64'(cap00[23*32 +: 32]), 64'h50101);
  endtask

  initial begin
    rst = 1'b1;
    vin[0] = 0; vin[1] = 0; md[0] = 0; md[1] = 0; ordy[0] = 1; ordy[1] = 1;
    d_in[0] = '0; d_in[1] = '0; rnd_or[0] = 0; rnd_or[1] = 0; bp_en = 0;
    clear_stats();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset.valid_out", 64'(valid_out0), 64'd0);
    chk("reset.frame_done", 64'(frame_done0), 64'd0);
    chk("reset.win_row", 64'(win_row0), 64'd0);
    chk("reset.win_col", 64'(win_col0), 64'd0);
    chk("reset.in_ready", 64'(in_ready0), 64'd1);
    chk_win("reset.win_out", w_out0, '0);
    @(posedge clk); #1;

    clear_stats();
    drive_frame(0, 884, 1'b0, -1, 1'b0, 0);
    settle();
    chk("pool.count", 64'(win_cnt[0]), 64'd221);
    chk_first_pool("pool");
    chk("pool.done_seen", 64'(done_seen), 64'd1);
    chk("pool.done_valid", 64'(done_v), 64'd1);
    chk("pool.done_row", 64'(done_r), 64'd32);
    chk("pool.done_col", 64'(done_c), 64'd24);

    clear_stats();
    drive_frame(0, 884, 1'b1, -1, 1'b0, 0);
    settle();
    chk("conv.count", 64'(win_cnt[0]), 64'd825);
    chk("conv.in_ready_low", 64'(irlow[0]), 64'd0);
    chk("conv.gap_00_01", 64'(t01 - t00), 64'd1);

    clear_stats();
    bp_en = 1'b1;
    drive_frame(0, 884, 1'b0, -1, 1'b0, 0);
    settle();
    bp_en = 1'b0;
    chk("bp.fired", 64'(bp_fired), 64'd1);
    chk("bp.held_cycles", 64'(held[0]), 64'd5);
    chk("bp.count", 64'(win_cnt[0]), 64'd221);

    clear_stats();
    drive_frame(0, 300, 1'b0, -1, 1'b1, 0);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_mid.valid_out", 64'(valid_out0), 64'd0);
    @(posedge clk); #1;
    clear_stats();
    drive_frame(0, 884, 1'b0, -1, 1'b0, 0);
    settle();
    chk("rst_mid.count", 64'(win_cnt[0]), 64'd221);
    chk_first_pool("rst_mid");

    clear_stats();
    drive_frame(1, 36, 1'b0, 10, 1'b0, 0);
    drive_frame(1, 36, 1'b1, -1, 1'b0, 0);
    settle();
    chk("gen.count", 64'(q1.size()), 64'd20);
    if (q1.size() >= 6) begin
      chk("gen.w0", 64'(q1[0]), 64'd0);
      chk("gen.w1", 64'(q1[1]), 64'd3);
      chk("gen.w2", 64'(q1[2]), 64'd24);
      chk("gen.w3", 64'(q1[3]), 64'd27);
      chk("gen.conv_w0", 64'(q1[4]), 64'd0);
      chk("gen.conv_w1", 64'(q1[5]), 64'd1);
    end

    clear_stats();
    rnd_or[0] = 1'b1;
    drive_frame(0, 884, 1'b0, -1, 1'b1, 50);
    rnd_or[0] = 1'b0;
    ordy[0] = 1'b1;
    settle();
    chk("rand.pool_count", 64'(win_cnt[0]), 64'd221);

    clear_stats();
    rnd_or[1] = 1'b1;
    drive_frame(1, 36, 1'b1, -1, 1'b1, 50);
    rnd_or[1] = 1'b0;
    ordy[1] = 1'b1;
    settle();
    chk("rand.gen_conv_count", 64'(win_cnt[1]), 64'd16);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mid_window_buffer.md
MID_WINDOW_BUFFER -- requirements
Module: mid_window_buffer

Interface
REQ-001 SHALL have parameter CH, default 32: feature-map channel count.
REQ-002 SHALL have parameter DW, default 32: data word width in bits.
REQ-003 SHALL have parameter IMG_H, default 34: frame rows.
REQ-004 SHALL have parameter IMG_W, default 26: frame columns.
REQ-005 SHALL have parameter WIN, default 2: square window edge, 2..min(IMG_H,IMG_W).
REQ-006 SHALL have ports: clk  in  1  rising-edge clock; one clock, synchronous reset, active-high.
REQ-007 SHALL have port rst_n  in  1  synchronous reset, active-high: asserted at 1, sampled on clk.
REQ-008 SHALL have port valid_in  in  1  pixel strobe.
REQ-009 SHALL have port in_ready  out  1  pixel accepted when valid_in && in_ready.
REQ-010 SHALL have port data_in  in  CH*DW  one pixel, channel c at bits [c*DW +: DW].
REQ-011 SHALL have port mode  in  1  0 = pool (stride WIN), 1 = conv (stride 1).
REQ-012 SHALL have port valid_out  out  1  window valid.
REQ-013 SHALL have port out_ready  in  1  window consumed when valid_out && out_ready.
REQ-014 SHALL have port win_out  out  CH*WIN*WIN*DW  window, element (c,r,k) at [((c*WIN+r)*WIN+k)*DW +: DW], r=0 oldest row, k=0 leftmost column.
REQ-015 SHALL have ports win_row/win_col  out  clog2(IMG_H)/clog2(IMG_W)  top-left pixel coordinates of the presented window.
REQ-016 SHALL have port frame_done  out  1  one-cycle pulse after the last pixel of a frame is accepted.

Function
REQ-017 SHALL accept pixels in raster order, column fastest, IMG_H*IMG_W pixels per frame.
REQ-018 SHALL implement FSM IDLE -> FILL on the first accepted pixel, FILL -> RUN on acceptance of pixel (WIN-1,WIN-1), RUN -> DONE on acceptance of the last pixel, and DONE -> IDLE on the following cycle.
REQ-019 SHALL sample mode only on the IDLE->FILL acceptance and hold it for the whole frame.
REQ-020 SHALL emit a window for accepted pixel (r,c) iff r>=WIN-1, c>=WIN-1, and in mode 0 (r-WIN+1)%WIN==0 && (c-WIN+1)%WIN==0; mode 1 emits on every such pixel.
REQ-021 SHALL assert valid_out, registered, one cycle after the completing pixel is accepted, with win_row=r-WIN+1 and win_col=c-WIN+1.
REQ-022 SHALL hold win_out, win_row and win_col stable while valid_out && !out_ready.
REQ-023 SHALL drive in_ready = !(valid_out && !out_ready); a held window stalls input and leaves no bubble once released.
REQ-024 SHALL store WIN-1 previous rows per channel in line buffers plus a WIN x WIN register window shifted on each accepted pixel; column wrap SHALL NOT mix rows.
REQ-025 SHALL pulse frame_done in the same cycle that the final window is presented.
REQ-026 SHALL ignore data_in when valid_in=0 and SHALL NOT advance any counter.
REQ-027 SHALL accept a new frame's first pixel in the cycle after DONE, with no gap otherwise required.

Reset
REQ-028 SHALL on rst_n=1 set state IDLE, row/col counters 0, valid_out=0, frame_done=0, win_row=win_col=0, win_out=0, and in_ready=1 after release.
REQ-029 SHALL abort an in-progress frame on a reset asserted mid-frame; the next accepted pixel is (0,0). Line-buffer contents are don't-care.

Structure
REQ-030 SHALL place the mode encoding enum, state enum and default geometry constants in shared package mid_buffer_pkg.
REQ-031 SHALL instantiate sub-module line_buffer (depth IMG_W, width CH*DW), used WIN-1 times, with a synchronous write/read enabled by pixel acceptance.

Verification
REQ-032 Pool check: defaults, mode=0, 884 pixels with value (ch<<16)|(r<<8)|c and out_ready=1 -> 221 windows; first window at (0,0) contains channel 5 values 0x50000,0x50001,0x50100,0x50101; frame_done coincides with window (32,24).
REQ-033 Conv check: mode=1, same stimulus -> 825 windows, in_ready constant 1, window (0,1) follows (0,0) one cycle later.
REQ-034 Backpressure check: mode=0, out_ready=0 for 5 cycles on window (2,4) -> valid_out held, outputs stable, in_ready=0, no pixel lost, total window count 221.
REQ-035 Mid-frame reset check: reset after pixel 300, then a full frame -> no valid_out during or just after reset; next frame windows match REQ-032.
REQ-036 Generic check: CH=4, WIN=3, IMG_H=IMG_W=6, mode=0 -> 4 windows at (0,0),(0,3),(3,0),(3,3); mode switched mid-frame is ignored until the next frame.
REQ-037 Idle gaps check: random valid_in duty 50% -> window contents and count identical to the gap-free run.
